// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB slave in front of a small register file. Each transfer takes a
//   programmable number of wait states. Accesses are checked for alignment,
//   address range, and non-secure access to the upper (secure) half. Errored
//   transfers have no side effect and are counted in a saturating counter.
//
// Ports
//   PCLK      in   sole clock, rising edge
//   PRESET    in   synchronous active-high reset
//   PSEL      in   slave select
//   PENABLE   in   access phase marker
//   PWRITE    in   1 = write, 0 = read
//   PADDR     in   byte address [ADDR_W]
//   PWDATA    in   write data [DATA_W]
//   PSTRB     in   write byte lanes [DATA_W/8], ignored on reads
//   PPROT     in   protection, bit 1 = non-secure
//   wait_cfg  in   wait states per transfer, clamped to WAIT_MAX
//   PRDATA    out  read data, nonzero only on a good read response
//   PREADY    out  registered transfer completion
//   PSLVERR   out  error response, only together with PREADY
//   err_cnt   out  saturating count of error responses
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int WAIT_MAX = 7
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic                            PSEL,
    input  logic                            PENABLE,
    input  logic                            PWRITE,
    input  logic [ADDR_W-1:0]               PADDR,
    input  logic [DATA_W-1:0]               PWDATA,
    input  logic [DATA_W/8-1:0]             PSTRB,
    input  logic [2:0]                      PPROT,
    input  logic [$clog2(WAIT_MAX+1)-1:0]   wait_cfg,
    output logic [DATA_W-1:0]               PRDATA,
    output logic                            PREADY,
    output logic                            PSLVERR,
    output logic [7:0]                      err_cnt
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs [DEPTH];

    // Transfer attributes captured in the setup cycle
    logic [IDX_W-1:0]  idx_q;
    logic              err_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BYTES-1:0]  strb_q;

    // Address decode of the live bus, used in the setup cycle
    logic              setup;
    logic [IDX_W-1:0]  addr_idx;
    logic              unaligned;
    logic              out_of_range;
    logic              secure_viol;
    logic              addr_err;
    logic [CNT_W-1:0]  wait_eff;

    // Only the secure/non-secure bit of PPROT has meaning for this slave
    logic              unused_prot;
    assign unused_prot = ^{PPROT[2], PPROT[0]};

    assign setup        = PSEL && !PENABLE;
    assign addr_idx     = IDX_W'(PADDR >> OFF_W);
    assign unaligned    = |(PADDR & ADDR_W'(BYTES - 1));
    assign out_of_range = |(PADDR >> (OFF_W + IDX_W));
    assign secure_viol  = PPROT[1] && addr_idx[IDX_W-1];
    assign addr_err     = unaligned || out_of_range || secure_viol;
    assign wait_eff     = (int'(wait_cfg) > WAIT_MAX) ? CNT_W'(WAIT_MAX) : wait_cfg;

    // A zero-wait transfer enters RESP straight from the setup cycle, before
    // the captured attributes are visible, so the response is built from the
    // live bus in that case and from the captured copy otherwise.
    logic              entering_resp;
    logic [IDX_W-1:0]  resp_idx;
    logic              resp_err;
    logic              resp_write;

    always_comb begin
        entering_resp = 1'b0;
        resp_idx      = idx_q;
        resp_err      = err_q;
        resp_write    = write_q;
        if (state == ST_IDLE) begin
            entering_resp = setup && (wait_eff == '0);
            resp_idx      = addr_idx;
            resp_err      = addr_err;
            resp_write    = PWRITE;
        end else if (state == ST_WAIT) begin
            entering_resp = PSEL && (cnt == CNT_W'(1));
        end
    end

    // Control: FSM, response outputs and error counter
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            err_cnt <= '0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            if (entering_resp) begin
                PREADY  <= 1'b1;
                PSLVERR <= resp_err;
                PRDATA  <= (resp_err || resp_write) ? '0 : regs[resp_idx];
            end
            case (state)
                ST_IDLE: begin
                    if (setup) begin
                        cnt   <= wait_eff;
                        state <= (wait_eff == '0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (PSLVERR && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Setup-cycle capture; only meaningful while a transfer is in flight
    always_ff @(posedge PCLK) begin
        if ((state == ST_IDLE) && setup) begin
            idx_q   <= addr_idx;
            err_q   <= addr_err;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
        end
    end

    // Register file: good writes commit on the edge that closes RESP
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if ((state == ST_RESP) && write_q && !err_q) begin
            for (int b = 0; b < BYTES; b++) begin
                if (strb_q[b]) begin
                    regs[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
//   Directed bench for apb_regfile_slave with default parameters
//   (ADDR_W=12, DATA_W=32, DEPTH=16, WAIT_MAX=7).
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [2:0]  wait_cfg;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  err_cnt;

    int errors  = 0;
    int checks  = 0;
    int bad_idle = 0;

    apb_regfile_slave #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .DEPTH    (16),
        .WAIT_MAX (7)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PPROT    (PPROT),
        .wait_cfg (wait_cfg),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .err_cnt  (err_cnt)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transfer. Called just after a rising edge; returns just
    // after the edge that closes the response cycle, bus idle, so a following
    // call issues its setup with no bubble.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input logic [2:0] wcfg,
                            output logic [31:0] rdata, output logic err,
                            output int cyc);
        bit got;
        got   = 1'b0;
        cyc   = 0;
        rdata = '0;
        err   = 1'b0;
        PSEL     = 1'b1;
        PENABLE  = 1'b0;
        PWRITE   = wr;
        PADDR    = addr;
        PWDATA   = data;
        PSTRB    = strb;
        PPROT    = prot;
        wait_cfg = wcfg;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        while (!got && cyc < 64) begin
            cyc++;
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                got   = 1'b1;
                rdata = PRDATA;
                err   = PSLVERR;
            end else if (PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
                bad_idle++;
            end
            @(posedge PCLK); #1;
        end
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        if (!got) cyc = 999;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cy;
    int          pulses;
    int          err_resps;

    initial begin
        PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0;
        PWDATA = '0; PSTRB = '0; PPROT = '0; wait_cfg = '0;

        // Reset state
        @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready", PREADY, 1'b0);
        chk("rst_pslverr", PSLVERR, 1'b0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Zero-wait write then read
        apb_xfer(1, 12'h004, 32'hDEADBEEF, 4'hF, 3'b000, 3'd0, rd, er, cy);
        chk("w0_cycles", cy, 1);
        chk("w0_err", er, 1'b0);
        apb_xfer(0, 12'h004, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("r0_cycles", cy, 1);
        chk("r0_data", rd, 32'hDEADBEEF);
        chk("r0_err", er, 1'b0);

        // Three wait states, partial byte write
        apb_xfer(1, 12'h008, 32'h11223344, 4'hF, 3'b000, 3'd0, rd, er, cy);
        apb_xfer(1, 12'h008, 32'h000000AA, 4'h1, 3'b000, 3'd3, rd, er, cy);
        chk("w3_cycles", cy, 4);
        chk("w3_err", er, 1'b0);
        apb_xfer(0, 12'h008, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("w3_readback", rd, 32'h112233AA);

        // All strobes off: completes, no change, no error
        apb_xfer(1, 12'h008, 32'hFFFFFFFF, 4'h0, 3'b000, 3'd2, rd, er, cy);
        chk("strb0_cycles", cy, 3);
        chk("strb0_err", er, 1'b0);
        apb_xfer(0, 12'h008, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("strb0_readback", rd, 32'h112233AA);

        // Unaligned and out-of-range reads
        apb_xfer(0, 12'h002, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("unalign_err", er, 1'b1);
        chk("unalign_data", rd, 32'h0);
        apb_xfer(0, 12'h040, 32'h0, 4'h0, 3'b000, 3'd1, rd, er, cy);
        chk("range_err", er, 1'b1);
        chk("range_data", rd, 32'h0);
        chk("range_cycles", cy, 2);
        chk("err_cnt_2", err_cnt, 8'd2);

        // Non-secure access to the secure half
        apb_xfer(1, 12'h020, 32'h00000001, 4'hF, 3'b010, 3'd0, rd, er, cy);
        chk("nsec_w_err", er, 1'b1);
        apb_xfer(0, 12'h020, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("nsec_unchanged", rd, 32'h0);
        apb_xfer(1, 12'h020, 32'h00000001, 4'hF, 3'b000, 3'd0, rd, er, cy);
        chk("sec_w_err", er, 1'b0);
        apb_xfer(0, 12'h020, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("sec_readback", rd, 32'h1);
        apb_xfer(0, 12'h004, 32'h0, 4'h0, 3'b010, 3'd0, rd, er, cy);
        chk("nsec_low_ok", er, 1'b0);
        chk("nsec_low_data", rd, 32'hDEADBEEF);
        chk("err_cnt_3", err_cnt, 8'd3);

        // Abort: PSEL dropped in the 2nd access cycle of a 5-wait write
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'h00C;
        PWDATA = 32'h55; PSTRB = 4'hF; PPROT = 3'b000; wait_cfg = 3'd5;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
        pulses = 0;
        repeat (10) begin
            @(negedge PCLK);
            if (PREADY !== 1'b0) pulses++;
        end
        chk("abort_no_pready", pulses, 0);
        chk("abort_err_cnt", err_cnt, 8'd3);
        @(posedge PCLK); #1;
        apb_xfer(0, 12'h00C, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
        chk("abort_no_write", rd, 32'h0);
        chk("abort_next_cycles", cy, 1);
        chk("abort_next_err", er, 1'b0);

        // Reset in the middle of a wait-state write
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'h010;
        PWDATA = 32'h77; PSTRB = 4'hF; PPROT = 3'b000; wait_cfg = 3'd5;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PRESET = 1; PSEL = 0; PENABLE = 0;
        @(posedge PCLK); #1;
        PRESET = 0;
        @(negedge PCLK);
        chk("mid_rst_pready", PREADY, 1'b0);
        chk("mid_rst_err_cnt", err_cnt, 8'd0);
        @(posedge PCLK); #1;
        for (int i = 0; i < 16; i++) begin
            apb_xfer(0, 12'(i * 4), 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
            chk($sformatf("rst_reg%0d", i), rd, 32'h0);
        end

        // 256 errored reads saturate the error counter
        err_resps = 0;
        for (int i = 0; i < 256; i++) begin
            apb_xfer(0, 12'h002, 32'h0, 4'h0, 3'b000, 3'd0, rd, er, cy);
            if (er === 1'b1) err_resps++;
        end
        chk("sat_err_resps", err_resps, 256);
        chk("sat_err_cnt", err_cnt, 8'd255);
        chk("idle_outputs_zero", bad_idle, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 Parameter ADDR_W, default 12, PADDR width in bits.
REQ-002 Parameter DATA_W, default 32, data width; legal values 8, 16, 32, 64.
REQ-003 Parameter DEPTH, default 16, number of DATA_W-bit registers; power of two, 2 to 256.
REQ-004 Parameter WAIT_MAX, default 7, maximum programmable wait states; 1 to 255.
REQ-005 PCLK  input  1  sole clock; all logic on the rising edge.
REQ-006 PRESET  input  1  reset; one clock; reset is synchronous and active-high.
REQ-007 PSEL  input  1  slave select.
REQ-008 PENABLE  input  1  access phase marker.
REQ-009 PWRITE  input  1  1 = write, 0 = read.
REQ-010 PADDR  input  ADDR_W  byte address.
REQ-011 PWDATA  input  DATA_W  write data.
REQ-012 PSTRB  input  DATA_W/8  write byte lanes; ignored on reads.
REQ-013 PPROT  input  3  protection; bit 1 = 1 means non-secure.
REQ-014 wait_cfg  input  clog2(WAIT_MAX+1)  wait states per transfer; sampled in the setup cycle; values above WAIT_MAX are clamped to WAIT_MAX.
REQ-015 PRDATA  output  DATA_W  read data; nonzero only while PREADY=1 on a read without error.
REQ-016 PREADY  output  1  transfer completion, registered.
REQ-017 PSLVERR  output  1  error response; may be 1 only while PREADY=1.
REQ-018 err_cnt  output  8  saturating count of error responses.

Function
REQ-019 FSM states: IDLE, WAIT, RESP.
- IDLE: PSEL=1 with PENABLE=0 (setup) latches address, direction, data, strobes, PPROT and the clamped wait_cfg; goes to RESP if the wait count is 0, otherwise to WAIT with cnt=wait count.
REQ-020 WAIT: cnt decrements each cycle; goes to RESP when cnt==1; goes to IDLE (abort) if PSEL=0.
REQ-021 RESP: PREADY=1 for exactly one cycle; then IDLE.
- Zero-wait transfer: PREADY=1 in the first access cycle.
- N wait states: PREADY=1 in access cycle N+1.
REQ-022 Back-to-back transfers: a setup in the cycle after RESP is accepted with no idle bubble.
REQ-023 Address decode:
- byte offset = PADDR[clog2(DATA_W/8)-1:0]
- index = the next clog2(DEPTH) bits
- address bits above index must be zero.
REQ-024 Error if any of the following holds:
- offset is nonzero (unaligned);
- the upper address bits are nonzero (out of range);
- PPROT[1]=1 and index >= DEPTH/2 (non-secure access to the secure half).
REQ-025 Write without error updates register[index] on the RESP edge, only for byte lanes with PSTRB bit set; PSTRB=0 completes with no change and no error.
REQ-026 Errored write has no side effect; errored read returns PRDATA=0.
REQ-027 Read data is registered from register[index] on entry to RESP and reflects writes completed in earlier transfers.
REQ-028 err_cnt increments by 1 on each RESP cycle with PSLVERR=1; holds at 255.
REQ-029 Aborted transfers perform no write, give no PREADY pulse and leave err_cnt unchanged.
REQ-030 Outside RESP, PREADY, PSLVERR and PRDATA are 0.
REQ-031 PENABLE=1 while in IDLE without a prior setup is ignored.

Reset
REQ-032 PRESET=1 at a clock edge sets:
- state = IDLE
- all registers = 0
- err_cnt = 0
- PREADY, PSLVERR, PRDATA = 0
REQ-033 Reset asserted during WAIT or RESP abandons the transfer with no write; the first setup accepted is the one after PRESET deasserts.

Verification
REQ-034 wait_cfg=0; write 0xDEADBEEF, PSTRB=0xF, to 0x004; read 0x004 -> PREADY in the first access cycle both times, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-035 wait_cfg=3; write 0x000000AA to 0x008 with PSTRB=0x1 over a register holding 0x11223344 -> PREADY in the 4th access cycle; readback 0x112233AA.
REQ-036 Read 0x002 (unaligned), then 0x040 (out of range for DEPTH=16) -> PSLVERR=1 with PRDATA=0 both times; err_cnt=2.
REQ-037 PPROT=3'b010; write 0x1 to 0x020 (index 8) -> PSLVERR=1, register unchanged; same write with PPROT=3'b000 -> success.
REQ-038 wait_cfg=5; drop PSEL in the 2nd access cycle of a write -> no PREADY, no write, err_cnt unchanged; next transfer completes normally.
REQ-039 Apply PRESET during WAIT, then perform 256 errored reads -> all registers read 0 and err_cnt saturates at 255.
